// File: rtl/video_frame_grab.sv
// rtl/video_frame_grab.sv - single-frame video capture buffer with channel-serial readout stream
// Arms on request, skips a configurable number of frames, stores one frame, then streams it out.
module video_frame_grab #(
    parameter int IMG_HDISP   = 640,
    parameter int IMG_VDISP   = 480,
    parameter int CHANNELS    = 3,
    parameter int CH_WIDTH    = 8,
    parameter int SKIP_FRAMES = 0,
    localparam int DEPTH      = IMG_HDISP * IMG_VDISP,
    localparam int DATA_WIDTH = CHANNELS * CH_WIDTH,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  video_vsync,
    input  logic                  video_hsync,
    input  logic                  video_de,
    input  logic [DATA_WIDTH-1:0] video_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overflow,
    output logic                  err_short,
    output logic [CW-1:0]         pix_count,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [CH_WIDTH-1:0]   rd_data,
    output logic                  rd_last
);

    localparam int SW  = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

    state_t                state;
    state_t                state_next;
    logic                  vsync_d1;
    logic                  frame_start;
    logic                  wr_en;
    logic                  beat;
    logic [SW-1:0]         skip_cnt;
    logic [CW-1:0]         rd_addr;
    logic [CHW-1:0]        ch_idx;
    logic [DATA_WIDTH-1:0] pix_reg;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic                  unused_inputs;

    assign unused_inputs = video_hsync;
    assign frame_start   = vsync_d1 & ~video_vsync;
    assign wr_en         = (state == CAPTURE) && video_de && (pix_count < CW'(DEPTH));
    assign beat          = rd_valid & rd_ready;
    assign busy          = (state != IDLE);
    // rd_addr already points past the pixel held in pix_reg
    assign rd_last       = rd_valid && (rd_addr == pix_count) && (ch_idx == '0);
    assign rd_data       = rd_valid ? pix_reg[int'(ch_idx)*CH_WIDTH +: CH_WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm) state_next = ARMED;
            ARMED:   if (frame_start && skip_cnt == '0) state_next = CAPTURE;
            CAPTURE: if (frame_start) state_next = READOUT;
            READOUT: begin
                if (pix_count == '0) begin
                    state_next = IDLE;
                end else if (beat && rd_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[pix_count[AW-1:0]] <= video_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d1     <= 1'b0;
            skip_cnt     <= '0;
            pix_count    <= '0;
            rd_addr      <= '0;
            ch_idx       <= '0;
            pix_reg      <= '0;
            rd_valid     <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            vsync_d1 <= video_vsync;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        skip_cnt     <= SW'(SKIP_FRAMES);
                        pix_count    <= '0;
                        rd_addr      <= '0;
                        err_overflow <= 1'b0;
                        err_short    <= 1'b0;
                    end
                end
                ARMED: begin
                    if (frame_start && skip_cnt != '0) begin
                        skip_cnt <= skip_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (wr_en) begin
                        pix_count <= pix_count + 1'b1;
                    end else if (video_de) begin
                        err_overflow <= 1'b1;
                    end
                    // a pixel arriving alongside the closing frame start still counts
                    if (frame_start) begin
                        err_short <= (pix_count + CW'(wr_en)) < CW'(DEPTH);
                    end
                end
                READOUT: begin
                    if (pix_count == '0) begin
                        done <= 1'b1;
                    end else if (!rd_valid) begin
                        pix_reg  <= mem[rd_addr[AW-1:0]];
                        rd_addr  <= rd_addr + 1'b1;
                        ch_idx   <= CHW'(CHANNELS - 1);
                        rd_valid <= 1'b1;
                    end else if (beat) begin
                        if (rd_last) begin
                            rd_valid <= 1'b0;
                            done     <= 1'b1;
                        end else if (ch_idx == '0) begin
                            pix_reg <= mem[rd_addr[AW-1:0]];
                            rd_addr <= rd_addr + 1'b1;
                            ch_idx  <= CHW'(CHANNELS - 1);
                        end else begin
                            ch_idx <= ch_idx - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_video_frame_grab.sv
// tb/tb_video_frame_grab.sv - randomized self-checking bench for video_frame_grab
// Two instances (skip 0 and skip 2) share the video bus; expected beats come from the frames the bench sends.
module tb_video_frame_grab;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int CH    = 3;
    localparam int DEPTH = H * V;
    localparam int PCW   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        video_vsync = 1'b0;
    logic        video_hsync = 1'b0;
    logic        video_de = 1'b0;
    logic [23:0] video_data = '0;
    logic        rd_ready = 1'b1;
    logic        rnd_ready = 1'b0;
    logic [1:0]  arm_v = '0;
    logic [1:0]  busy_v, done_v, ovf_v, short_v, rd_valid_v, rd_last_v;
    logic [PCW-1:0] pc_v [2];
    logic [7:0]  rd_data_v [2];

    logic [8:0]  exp_q [2][$];
    int          errors = 0;
    int          checks = 0;

    video_frame_grab #(.IMG_HDISP(H), .IMG_VDISP(V), .CHANNELS(CH), .CH_WIDTH(8), .SKIP_FRAMES(0)) dut0 (
        .clk(clk), .rst(rst), .arm(arm_v[0]), .video_vsync(video_vsync), .video_hsync(video_hsync),
        .video_de(video_de), .video_data(video_data), .busy(busy_v[0]), .done(done_v[0]),
        .err_overflow(ovf_v[0]), .err_short(short_v[0]), .pix_count(pc_v[0]),
        .rd_valid(rd_valid_v[0]), .rd_ready(rd_ready), .rd_data(rd_data_v[0]), .rd_last(rd_last_v[0]));

    video_frame_grab #(.IMG_HDISP(H), .IMG_VDISP(V), .CHANNELS(CH), .CH_WIDTH(8), .SKIP_FRAMES(2)) dut1 (
        .clk(clk), .rst(rst), .arm(arm_v[1]), .video_vsync(video_vsync), .video_hsync(video_hsync),
        .video_de(video_de), .video_data(video_data), .busy(busy_v[1]), .done(done_v[1]),
        .err_overflow(ovf_v[1]), .err_short(short_v[1]), .pix_count(pc_v[1]),
        .rd_valid(rd_valid_v[1]), .rd_ready(rd_ready), .rd_data(rd_data_v[1]), .rd_last(rd_last_v[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        rd_ready = rnd_ready ? 1'($urandom) : 1'b1;
    end

    // Stream scoreboard: every handshake pops one expected beat, stalls must hold the beat
    logic [1:0] stall_prev = '0;
    logic [8:0] held [2];
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (stall_prev[i]) begin
                    chk("stall_hold", {rd_valid_v[i], rd_last_v[i], rd_data_v[i]}, {1'b1, held[i]});
                end
                if (rd_valid_v[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk("unexpected_beat", 32'(rd_valid_v[i]), 0);
                    end else if (rd_ready) begin
                        chk("beat", {rd_last_v[i], rd_data_v[i]}, exp_q[i].pop_front());
                    end
                end
                stall_prev[i] = rd_valid_v[i] & ~rd_ready;
                held[i] = {rd_last_v[i], rd_data_v[i]};
            end
        end
    end

    task automatic check_zero(input int i);
        chk("rst_busy", busy_v[i], 0);
        chk("rst_done", done_v[i], 0);
        chk("rst_ovf", ovf_v[i], 0);
        chk("rst_short", short_v[i], 0);
        chk("rst_pix_count", pc_v[i], 0);
        chk("rst_rd_valid", rd_valid_v[i], 0);
        chk("rst_rd_last", rd_last_v[i], 0);
        chk("rst_rd_data", rd_data_v[i], 0);
    endtask

    task automatic do_arm(input int i);
        arm_v[i] = 1'b1;
        tick;
        arm_v = '0;
    endtask

    // One frame: vsync pulse, falling edge, n de pixels with random gaps
    task automatic send_frame(input int n, input int cap, input bit directed);
        logic [23:0] pix;
        int last_p;
        last_p = ((n < DEPTH) ? n : DEPTH) - 1;
        video_vsync = 1'b1; video_de = 1'b0;
        tick; tick;
        video_vsync = 1'b0;
        tick;
        for (int p = 0; p < n; p++) begin
            repeat ($urandom_range(0, 2)) begin
                video_de = 1'b0; video_data = 24'($urandom); video_hsync = 1'($urandom);
                tick;
            end
            pix = directed ? {8'(3*p+1), 8'(3*p+2), 8'(3*p+3)} : 24'($urandom);
            video_de = 1'b1; video_data = pix;
            tick;
            if (cap >= 0 && p < DEPTH) begin
                for (int c = CH - 1; c >= 0; c--) begin
                    exp_q[cap].push_back({(p == last_p) && (c == 0), pix[c*8 +: 8]});
                end
            end
        end
        video_de = 1'b0;
        tick;
    endtask

    task automatic close_frame(input int i, input bit lat, input bit sh, input bit nonempty);
        video_vsync = 1'b1; video_de = 1'b0;
        tick; tick;
        video_vsync = 1'b0;
        tick;
        if (lat) begin
            chk("lat_t1_valid", rd_valid_v[i], 0);
            chk("lat_t1_busy", busy_v[i], 1);
            chk("short_t1", short_v[i], 32'(sh));
            tick;
            chk("lat_t2_valid", rd_valid_v[i], 32'(nonempty));
        end
    endtask

    task automatic wait_done(input int i, input int pc, input bit ovf, input bit sh);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done_v[i]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", done_v[i], 1);
        if (seen) begin
            chk("done_busy", busy_v[i], 0);
            chk("pix_count", pc_v[i], pc);
            chk("err_overflow", ovf_v[i], 32'(ovf));
            chk("err_short", short_v[i], 32'(sh));
            chk("beats_left", exp_q[i].size(), 0);
            @(negedge clk);
            chk("done_pulse_end", done_v[i], 0);
            chk("pix_count_hold", pc_v[i], pc);
            chk("rd_valid_idle", rd_valid_v[i], 0);
        end
    endtask

    task automatic run_capture(input int i, input int n_last, input bit directed, input bit lat);
        int nf;
        nf = (i == 0) ? 1 : 3;
        do_arm(i);
        for (int f = 0; f < nf; f++) begin
            if (f == nf - 1) send_frame(n_last, i, directed);
            else send_frame($urandom_range(0, 11), -1, 1'b0);
        end
        close_frame(i, lat, n_last < DEPTH, n_last > 0);
        wait_done(i, (n_last < DEPTH) ? n_last : DEPTH, n_last > DEPTH, n_last < DEPTH);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick;
        check_zero(0);
        check_zero(1);
        rst = 1'b0;
        tick;

        // 8-pixel directed frame, continuous ready
        do_arm(0);
        send_frame(8, 0, 1'b1);
        chk("model_size", exp_q[0].size(), 24);
        chk("model_first", exp_q[0][0], 9'h001);
        chk("model_last", exp_q[0][23], 9'h118);
        close_frame(0, 1'b1, 1'b0, 1'b1);
        wait_done(0, 8, 1'b0, 1'b0);

        // skip two frames, random ready
        rnd_ready = 1'b1;
        run_capture(1, 8, 1'b0, 1'b1);
        rnd_ready = 1'b0;

        run_capture(0, 10, 1'b0, 1'b1);
        run_capture(0, 5, 1'b0, 1'b1);
        run_capture(0, 0, 1'b0, 1'b1);

        // directed sequence again under random stalls
        rnd_ready = 1'b1;
        run_capture(0, 8, 1'b1, 1'b1);

        for (int it = 0; it < 8; it++) begin
            run_capture(int'($urandom_range(0, 1)), $urandom_range(0, 11), 1'b0, 1'($urandom));
        end

        // reset mid-capture
        do_arm(0);
        video_vsync = 1'b1; tick; tick;
        video_vsync = 1'b0; tick;
        repeat (3) begin
            video_de = 1'b1; video_data = 24'($urandom); tick;
        end
        video_de = 1'b0;
        chk("mid_capture_busy", busy_v[0], 1);
        rst = 1'b1;
        tick;
        check_zero(0);
        rst = 1'b0;
        exp_q[0].delete();
        tick;

        // reset mid-readout
        do_arm(0);
        send_frame(8, 0, 1'b0);
        close_frame(0, 1'b0, 1'b0, 1'b1);
        tick; tick;
        chk("mid_readout_valid", rd_valid_v[0], 1);
        rst = 1'b1;
        tick;
        check_zero(0);
        rst = 1'b0;
        exp_q[0].delete();
        tick;

        run_capture(0, 8, 1'b1, 1'b1);
        run_capture(1, 7, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_frame_grab.md
VIDEO_FRAME_GRAB -- requirements
Module: video_frame_grab

Interface
REQ-001 SHALL: parameter IMG_HDISP, default 640, active pixels per line.
REQ-002 SHALL: parameter IMG_VDISP, default 480, active lines per frame.
REQ-003 SHALL: parameter CHANNELS, default 3, colour channels per pixel.
REQ-004 SHALL: parameter CH_WIDTH, default 8, bits per channel.
REQ-005 SHALL: parameter SKIP_FRAMES, default 0, frame starts ignored after arm before the captured frame.
REQ-006 SHALL: derived DEPTH = IMG_HDISP*IMG_VDISP; DATA_WIDTH = CHANNELS*CH_WIDTH; CW = $clog2(DEPTH+1).
REQ-007 SHALL: one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-008 SHALL: clk  in  1  sole clock, all logic on rising edge.
REQ-009 SHALL: rst  in  1  synchronous active-high reset.
REQ-010 SHALL: arm  in  1  single-cycle request to capture one frame.
REQ-011 SHALL: video_vsync  in  1  frame sync; falling edge marks frame start.
REQ-012 SHALL: video_hsync  in  1  line sync; ignored by this block.
REQ-013 SHALL: video_de  in  1  pixel valid.
REQ-014 SHALL: video_data  in  DATA_WIDTH  pixel; channel k at bits [k*CH_WIDTH +: CH_WIDTH].
REQ-015 SHALL: busy  out  1  high in any state other than IDLE.
REQ-016 SHALL: done  out  1  one-cycle pulse when readout completes.
REQ-017 SHALL: err_overflow  out  1  sticky: more than DEPTH pixels in captured frame.
REQ-018 SHALL: err_short  out  1  sticky: fewer than DEPTH pixels in captured frame.
REQ-019 SHALL: pix_count  out  CW  pixels stored in last capture.
REQ-020 SHALL: rd_valid  out  1; rd_ready  in  1; rd_data  out  CH_WIDTH; rd_last  out  1  channel-serial readout stream.

Function
REQ-021 SHALL: edge detect uses registered vsync_d1; frame start = vsync_d1 & !video_vsync.
REQ-022 SHALL: states IDLE, ARMED, CAPTURE, READOUT; arm accepted only in IDLE, ignored elsewhere.
REQ-023 SHALL: IDLE + arm -> ARMED next cycle; skip counter loads SKIP_FRAMES; err flags and pix_count clear; a frame start in the same cycle as arm is not counted.
REQ-024 SHALL: ARMED + frame start: counter==0 -> CAPTURE, else counter decrements.
REQ-025 SHALL: CAPTURE: each cycle with video_de and write address < DEPTH stores video_data at address, address and pix_count increment same cycle.
REQ-026 SHALL: CAPTURE: video_de with address == DEPTH drops pixel, sets err_overflow.
REQ-027 SHALL: CAPTURE + frame start (cycle T) -> READOUT at T+1; pix_count < DEPTH sets err_short at T+1; video_de in cycle T is still stored.
REQ-028 SHALL: READOUT with pix_count==0 -> IDLE immediately, done pulses, rd_valid never asserts.
REQ-029 SHALL: READOUT order: pixel 0 to pix_count-1; within pixel, channel CHANNELS-1 first down to channel 0.
REQ-030 SHALL: first rd_valid at T+2; one beat transfers per cycle with rd_valid & rd_ready; rd_data/rd_last held stable while rd_valid & !rd_ready.
REQ-031 SHALL: total beats = pix_count*CHANNELS; rd_last high only on final beat.
REQ-032 SHALL: final beat handshake -> IDLE next cycle with done=1 for that one cycle; rd_valid low in IDLE.
REQ-033 SHALL: err flags and pix_count hold after done until next accepted arm.
REQ-034 SHALL: video inputs ignored outside CAPTURE (except edge detection).

Reset
REQ-035 SHALL: rst forces IDLE, vsync_d1=0, skip counter, addresses, pix_count=0, busy=0, done=0, err_overflow=0, err_short=0, rd_valid=0, rd_last=0, rd_data=0, in any state including mid-capture and mid-readout.
REQ-036 SHALL: buffer contents need not be cleared by reset.

Verification (IMG_HDISP=4, IMG_VDISP=2, CHANNELS=3, CH_WIDTH=8)
REQ-037 SHALL: arm, SKIP_FRAMES=0, frame of 8 pixels 0x010203..0x161718, rd_ready=1 -> 24 beats 01,02,03,...,16,17,18; rd_last on 24th; done 1 cycle; pix_count=8, no errors.
REQ-038 SHALL: SKIP_FRAMES=2, three frames with distinct pixel values -> only third frame read out.
REQ-039 SHALL: frame of 10 de pixels -> first 8 read out, err_overflow=1, pix_count=8.
REQ-040 SHALL: frame of 5 pixels -> 15 beats, err_short=1, pix_count=5; empty frame -> done with no rd_valid, err_short=1.
REQ-041 SHALL: rd_ready toggled 1-0-1 random -> rd_data stable while stalled, sequence identical to REQ-037.
REQ-042 SHALL: rst asserted mid-CAPTURE and mid-READOUT -> all outputs 0 next cycle, busy=0; subsequent arm captures correctly.
